// File: rtl/zz_vid_pkg.sv
// zz_vid_pkg: shared defaults, tag bit positions, FSM encoding and word size for the video stream source.
//   DATA_W_DEF / ADDR_W_DEF : default pixel word and byte address widths
//   TAG_SOF / TAG_EOL       : bit positions of start-of-frame / end-of-line in a 2-bit tag
//   state_t                 : fetch FSM states
//   WORD_BYTES              : bytes per pixel word
package zz_vid_pkg;
   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 32;
   localparam int TAG_SOF    = 1;
   localparam int TAG_EOL    = 0;
   localparam int WORD_BYTES = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, LATCH = 2'd1, FETCH = 2'd2, DRAIN = 2'd3} state_t;
endpackage

// File: rtl/vid_fifo_sync.sv
// vid_fifo_sync: single-clock first-word-fall-through FIFO.
//   clk, aresetn (sync, active-low) | push/din write | pop read | dout = head entry
//   full, empty, count = current occupancy (0..DEPTH)
//   A push and a pop in the same cycle both take effect, also when full.
module vid_fifo_sync #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     aresetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             wr_en, rd_en;
   assign empty = count == '0;
   assign full  = count == CW'(DEPTH);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign dout  = mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(wr_en);
         rd_ptr <= rd_ptr + AW'(rd_en);
         count  <= count + CW'(wr_en) - CW'(rd_en);
      end
   end
   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr] <= din;
endmodule

// File: rtl/vid_stream_source.sv
// vid_stream_source: AXI4-Stream video master replaying a framebuffer from an in-order read port.
//   m_axis_vid_aclk, aresetn (sync, active-low)
//   cfg_*      : enable, base, stride, width, height; sampled only when a frame starts
//   rd_*       : request/grant address channel, in-order rvalid/rdata responses
//   m_axis_vid : tdata/tvalid/tready/tlast (end of line)/tuser (start of frame)
//   busy, frame_done (pulse on last word handshake), cfg_error (sticky until enable drops)
module vid_stream_source
   import zz_vid_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int FIFO_DEPTH = 16
) (
   input  logic              m_axis_vid_aclk,
   input  logic              aresetn,
   input  logic              cfg_enable,
   input  logic [ADDR_W-1:0] cfg_base_addr,
   input  logic [ADDR_W-1:0] cfg_stride,
   input  logic [11:0]       cfg_width,
   input  logic [11:0]       cfg_height,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_gnt,
   input  logic              rd_rvalid,
   input  logic [DATA_W-1:0] rd_rdata,
   output logic [DATA_W-1:0] m_axis_vid_tdata,
   output logic              m_axis_vid_tvalid,
   input  logic              m_axis_vid_tready,
   output logic              m_axis_vid_tlast,
   output logic              m_axis_vid_tuser,
   output logic              busy,
   output logic              frame_done,
   output logic              cfg_error
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int OW = DATA_W + 2;
   localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(WORD_BYTES - 1);
   state_t            state;
   logic [ADDR_W-1:0] stride_q, line_addr;
   logic [11:0]       w_q, h_q, x, y, out_y;
   logic              cfg_ok, credit, gnt, eol, last_word, drained, hs;
   logic              tag_full, tag_empty, out_full, out_empty, pq_valid;
   logic [1:0]        tag_din, tag_dout;
   logic [CW-1:0]     outstanding, out_count;
   logic [CW:0]       occ;
   logic [OW-1:0]     pq_data, out_dout;
   assign cfg_ok    = |cfg_width && |cfg_height;
   assign eol       = x == w_q - 12'd1;
   assign last_word = eol && y == h_q - 12'd1;
   // Occupancy includes the response staging register so a granted read always has a FIFO slot.
   assign occ       = {1'b0, outstanding} + {1'b0, out_count} + (CW + 1)'(pq_valid);
   assign credit    = occ < (CW + 1)'(FIFO_DEPTH);
   assign rd_req    = state == FETCH && credit && !tag_full && !out_full;
   assign gnt       = rd_req && rd_gnt;
   assign drained   = tag_empty && out_empty && !pq_valid;
   assign busy      = state != IDLE;
   always_comb begin
      tag_din          = '0;
      tag_din[TAG_SOF] = x == 12'd0 && y == 12'd0;
      tag_din[TAG_EOL] = eol;
   end
   always_ff @(posedge m_axis_vid_aclk) begin
      if (!aresetn) begin
         state     <= IDLE;
         cfg_error <= 1'b0;
         stride_q  <= '0;
         line_addr <= '0;
         rd_addr   <= '0;
         w_q       <= '0;
         h_q       <= '0;
         x         <= '0;
         y         <= '0;
      end else begin
         cfg_error <= cfg_enable && (cfg_error || (state == IDLE && !cfg_ok));
         case (state)
            IDLE: if (cfg_enable && cfg_ok) state <= LATCH;
            LATCH: begin
               line_addr <= cfg_base_addr & ALIGN;
               rd_addr   <= cfg_base_addr & ALIGN;
               stride_q  <= cfg_stride & ALIGN;
               w_q       <= cfg_width;
               h_q       <= cfg_height;
               x         <= '0;
               y         <= '0;
               state     <= FETCH;
            end
            FETCH: if (gnt) begin
               x         <= eol ? 12'd0 : x + 12'd1;
               y         <= eol ? y + 12'd1 : y;
               line_addr <= eol ? line_addr + stride_q : line_addr;
               rd_addr   <= eol ? line_addr + stride_q : rd_addr + ADDR_W'(WORD_BYTES);
               if (last_word) state <= DRAIN;
            end
            DRAIN: if (drained) state <= (cfg_enable && cfg_ok) ? LATCH : IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   // Tag FIFO occupancy doubles as the outstanding-read count.
   vid_fifo_sync #(.WIDTH(2), .DEPTH(FIFO_DEPTH)) u_tag (
      .clk(m_axis_vid_aclk), .aresetn(aresetn), .push(gnt), .din(tag_din), .pop(rd_rvalid),
      .dout(tag_dout), .full(tag_full), .empty(tag_empty), .count(outstanding)
   );
   // Responses are staged one cycle before the output FIFO, giving a registered path from rd_rdata.
   always_ff @(posedge m_axis_vid_aclk) begin
      if (!aresetn) begin
         pq_valid <= 1'b0;
         pq_data  <= '0;
         out_y    <= '0;
      end else begin
         pq_valid <= rd_rvalid;
         pq_data  <= {tag_dout, rd_rdata};
         if (hs && m_axis_vid_tlast) out_y <= frame_done ? 12'd0 : out_y + 12'd1;
      end
   end
   vid_fifo_sync #(.WIDTH(OW), .DEPTH(FIFO_DEPTH)) u_out (
      .clk(m_axis_vid_aclk), .aresetn(aresetn), .push(pq_valid), .din(pq_data), .pop(hs),
      .dout(out_dout), .full(out_full), .empty(out_empty), .count(out_count)
   );
   assign m_axis_vid_tvalid = !out_empty;
   assign m_axis_vid_tdata  = out_dout[DATA_W-1:0];
   assign m_axis_vid_tuser  = !out_empty && out_dout[DATA_W+TAG_SOF];
   assign m_axis_vid_tlast  = !out_empty && out_dout[DATA_W+TAG_EOL];
   assign hs                = m_axis_vid_tvalid && m_axis_vid_tready;
   assign frame_done        = hs && m_axis_vid_tlast && out_y == h_q - 12'd1;
endmodule

// File: tb/tb_vid_stream_source.sv
// tb_vid_stream_source: directed bench with a latency-programmable in-order memory and an output scoreboard.
module tb_vid_stream_source;
   typedef struct {logic [31:0] data; logic sof; logic eol; logic last;} word_t;
   typedef struct {int due; logic [31:0] addr;} req_t;
   logic        clk, aresetn, cfg_enable;
   logic [31:0] cfg_base_addr, cfg_stride;
   logic [11:0] cfg_width, cfg_height;
   logic        rd_req, rd_gnt, rd_rvalid;
   logic [31:0] rd_addr, rd_rdata, m_axis_vid_tdata;
   logic        m_axis_vid_tvalid, m_axis_vid_tready, m_axis_vid_tlast, m_axis_vid_tuser;
   logic        busy, frame_done, cfg_error;
   int          checks = 0, errors = 0;
   int          cyc = 0, accepted = 0, fd_cnt = 0, req_cycles = 0, rv_cnt = 0;
   int          occ = 0, max_occ = 0, first_rv = -1, first_tv = -1;
   int          lat_fixed = 3;
   bit          lat_rand = 0, gnt_rand = 0, rdy_rand = 0, rdy_fixed = 0;
   word_t       exp_q[$];
   logic [31:0] addr_q[$];
   req_t        pend[$];

   vid_stream_source dut (
      .m_axis_vid_aclk(clk), .aresetn(aresetn), .cfg_enable(cfg_enable),
      .cfg_base_addr(cfg_base_addr), .cfg_stride(cfg_stride), .cfg_width(cfg_width),
      .cfg_height(cfg_height), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata), .m_axis_vid_tdata(m_axis_vid_tdata),
      .m_axis_vid_tvalid(m_axis_vid_tvalid), .m_axis_vid_tready(m_axis_vid_tready),
      .m_axis_vid_tlast(m_axis_vid_tlast), .m_axis_vid_tuser(m_axis_vid_tuser),
      .busy(busy), .frame_done(frame_done), .cfg_error(cfg_error)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory: a grant in cycle g answers in cycle g+latency, strictly in order.
   initial begin : memory
      int    due, last_due;
      logic [31:0] ra;
      last_due = 0;
      rd_gnt = 0; rd_rvalid = 0; rd_rdata = '0; m_axis_vid_tready = 0;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            pend.delete();
            last_due = 0;
         end else if (rd_req && rd_gnt) begin
            due = cyc + (lat_rand ? int'($urandom_range(1, 10)) : lat_fixed);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            ra = rd_addr;
            pend.push_back('{due: due, addr: ra});
         end
         @(posedge clk);
         #1;
         cyc++;
         rd_rvalid = 0;
         if (pend.size() != 0 && pend[0].due <= cyc) begin
            rd_rvalid = 1;
            rd_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
         end
         rd_gnt = gnt_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
         m_axis_vid_tready = rdy_rand ? ($urandom_range(0, 9) < 3) : rdy_fixed;
      end
   end

   // Scoreboard: request addresses, output words, frame_done, AXIS stability, credit bound.
   initial begin : monitor
      word_t       e;
      logic        hs, prev_stall;
      logic [33:0] prev_pl;
      prev_stall = 0;
      prev_pl = '0;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            prev_stall = 0;
            occ = 0;
         end else begin
            if (occ > max_occ) max_occ = occ;
            hs = m_axis_vid_tvalid && m_axis_vid_tready;
            if (rd_req) req_cycles++;
            if (rd_rvalid) begin
               rv_cnt++;
               if (first_rv < 0) first_rv = cyc;
            end
            if (m_axis_vid_tvalid && first_tv < 0) first_tv = cyc;
            if (rd_req && rd_gnt) begin
               check("req_planned", addr_q.size() != 0, 1);
               if (addr_q.size() != 0) check("rd_addr", rd_addr, addr_q.pop_front());
            end
            if (hs) begin
               check("word_planned", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("tdata", m_axis_vid_tdata, e.data);
                  check("tuser", m_axis_vid_tuser, e.sof);
                  check("tlast", m_axis_vid_tlast, e.eol);
                  check("frame_done", frame_done, e.last);
               end
               accepted++;
            end else check("frame_done_idle", frame_done, 0);
            if (frame_done) fd_cnt++;
            if (prev_stall) begin
               check("stall_tvalid", m_axis_vid_tvalid, 1);
               check("stall_payload", {m_axis_vid_tdata, m_axis_vid_tuser, m_axis_vid_tlast}, prev_pl);
            end
            prev_stall = m_axis_vid_tvalid && !m_axis_vid_tready;
            prev_pl = {m_axis_vid_tdata, m_axis_vid_tuser, m_axis_vid_tlast};
            occ = occ + int'(rd_req && rd_gnt) - int'(hs);
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic plan(int w, int h, logic [31:0] base, logic [31:0] stride);
      logic [31:0] a;
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++) begin
            a = base + y * stride + x * 4;
            addr_q.push_back(a);
            exp_q.push_back('{data: mem_word(a), sof: (x == 0 && y == 0), eol: (x == w - 1),
                              last: (x == w - 1 && y == h - 1)});
         end
   endtask

   task automatic wait_acc(int n, string tag);
      for (int i = 0; i < 5000 && accepted < n; i++) @(negedge clk);
      check({"reach_", tag}, accepted >= n, 1);
   endtask

   task automatic wait_idle(string tag);
      for (int i = 0; i < 5000 && busy; i++) @(negedge clk);
      check({"idle_", tag}, busy, 0);
   endtask

   task automatic finish_run(int words, int frames, string tag);
      wait_idle(tag);
      tick(3);
      check({"words_", tag}, accepted, words);
      check({"frames_", tag}, fd_cnt, frames);
      check({"exp_left_", tag}, exp_q.size(), 0);
      check({"addr_left_", tag}, addr_q.size(), 0);
   endtask

   // Runs n identical frames, dropping enable once drop_at words have been accepted.
   task automatic run_frames(int w, int h, logic [31:0] base, logic [31:0] stride, int n, int drop_at, string tag);
      accepted = 0;
      fd_cnt = 0;
      for (int f = 0; f < n; f++) plan(w, h, base, stride);
      cfg_width = 12'(w); cfg_height = 12'(h); cfg_base_addr = base; cfg_stride = stride;
      cfg_enable = 1;
      wait_acc(drop_at, tag);
      cfg_enable = 0;
      finish_run(n * w * h, n, tag);
   endtask

   initial begin : stim
      int req0;
      aresetn = 0; cfg_enable = 0; cfg_base_addr = '0; cfg_stride = '0; cfg_width = '0; cfg_height = '0;
      tick(3);
      check("rst_rd_req", rd_req, 0);
      check("rst_tvalid", m_axis_vid_tvalid, 0);
      check("rst_tlast", m_axis_vid_tlast, 0);
      check("rst_tuser", m_axis_vid_tuser, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_cfg_error", cfg_error, 0);
      aresetn = 1;
      rdy_fixed = 1;
      tick(2);

      // 4x2 frames at 0x1000 stride 0x20, latency 3; second frame restarts at 0x1000.
      first_rv = -1; first_tv = -1;
      run_frames(4, 2, 32'h1000, 32'h20, 2, 9, "basic");
      check("first_tvalid_latency", first_tv - first_rv, 2);

      // Width 1 and a 1x1 frame: every word is end of line; the single word carries both flags.
      run_frames(1, 3, 32'h3000, 32'h10, 1, 1, "w1");
      run_frames(1, 1, 32'h3800, 32'h10, 1, 1, "1x1");

      // Address wrap at the top of the address space.
      run_frames(2, 2, 32'hFFFF_FFF8, 32'h8, 1, 1, "wrap");

      // Random backpressure, grants and latency.
      lat_rand = 1; gnt_rand = 1; rdy_rand = 1;
      run_frames(5, 3, 32'h2000, 32'h40, 2, 16, "random");
      lat_rand = 0; gnt_rand = 0; rdy_rand = 0; lat_fixed = 3;

      // Enable dropped at word 2 of a 4x4 frame: the whole frame still goes out, then nothing.
      run_frames(4, 4, 32'h6000, 32'h20, 1, 2, "drop");
      req0 = req_cycles;
      tick(10);
      check("drop_no_req", req_cycles - req0, 0);
      check("drop_busy", busy, 0);

      // Width changed mid-frame only affects the next frame.
      accepted = 0; fd_cnt = 0;
      plan(4, 2, 32'h7000, 32'h40);
      plan(8, 2, 32'h7000, 32'h40);
      cfg_width = 4; cfg_height = 2; cfg_base_addr = 32'h7000; cfg_stride = 32'h40;
      cfg_enable = 1;
      wait_acc(2, "wchg_a");
      cfg_width = 8;
      wait_acc(10, "wchg_b");
      cfg_enable = 0;
      finish_run(24, 2, "wchg");

      // Height 0: error flag, no reads; cleared when enable drops.
      cfg_width = 4; cfg_height = 0;
      req0 = req_cycles;
      cfg_enable = 1;
      tick(10);
      check("h0_cfg_error", cfg_error, 1);
      check("h0_busy", busy, 0);
      check("h0_no_req", req_cycles - req0, 0);
      cfg_enable = 0;
      tick(2);
      check("h0_cfg_error_clr", cfg_error, 0);

      // Reset in FETCH with the output FIFO stalled and half full.
      rdy_fixed = 0; lat_fixed = 1; rv_cnt = 0;
      plan(16, 2, 32'h4000, 32'h100);
      cfg_width = 16; cfg_height = 2; cfg_base_addr = 32'h4000; cfg_stride = 32'h100;
      cfg_enable = 1;
      for (int i = 0; i < 200 && rv_cnt < 8; i++) @(negedge clk);
      check("rst_fill", rv_cnt >= 8, 1);
      check("rst_pre_busy", busy, 1);
      aresetn = 0;
      cfg_enable = 0;
      tick(1);
      check("rst_mid_tvalid", m_axis_vid_tvalid, 0);
      check("rst_mid_rd_req", rd_req, 0);
      check("rst_mid_busy", busy, 0);
      exp_q.delete();
      addr_q.delete();
      tick(2);
      aresetn = 1;
      rdy_fixed = 1;
      lat_fixed = 2;
      tick(2);
      run_frames(2, 2, 32'h5000, 32'h10, 1, 1, "post_rst");

      check("max_occupancy_le_16", max_occ <= 16, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
